// File: rtl/cmp_flag_unit.sv
// Multi-cycle subtract-and-compare unit: computes op_a - op_b one chunk per cycle
// (LSB first), then publishes diff and {N,Z,C,V} flags atomically and evaluates a branch condition.
module cmp_flag_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp_valid,
  output logic             cmp_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       cond,
  output logic [WIDTH-1:0] diff,
  output logic [3:0]       flags,
  output logic             flags_valid,
  output logic             done,
  output logic             branch_taken
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic             carry;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;

  assign cmp_ready = (state == IDLE) && !reset;

  // Current chunk adder; work_next is the accumulated result with this chunk merged in.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    sum = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, carry};
    work_next = work;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        work_next[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      end
    end
  end

  assign flag_n = work_next[WIDTH-1];
  assign flag_z = (work_next == '0);
  assign flag_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_next[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      work        <= '0;
      carry       <= 1'b0;
      diff        <= '0;
      flags       <= '0;
      flags_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmp_valid) begin
            a_q         <= op_a;
            b_q         <= op_b;
            work        <= '0;
            carry       <= 1'b1;
            cnt         <= '0;
            flags_valid <= 1'b0;
            state       <= CALC;
          end
        end
        CALC: begin
          work  <= work_next;
          carry <= sum[CHUNK];
          cnt   <= cnt + CW'(1);
          // Only the final chunk exposes a result, so diff never shows a partial value.
          if (cnt == LAST) begin
            diff        <= work_next;
            flags       <= {flag_n, flag_z, sum[CHUNK], flag_v};
            flags_valid <= 1'b1;
            done        <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // flags = {N,Z,C,V}; without a valid result only "always" is taken.
  always_comb begin
    branch_taken = 1'b0;
    if (!flags_valid) begin
      branch_taken = (cond == 3'd6);
    end else begin
      case (cond)
        3'd0: branch_taken = flags[2];
        3'd1: branch_taken = !flags[2];
        3'd2: branch_taken = !flags[1];
        3'd3: branch_taken = flags[1];
        3'd4: branch_taken = flags[3] ^ flags[0];
        3'd5: branch_taken = !(flags[3] ^ flags[0]);
        3'd6: branch_taken = 1'b1;
        default: branch_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_flag_unit.sv
// Directed-vector bench for cmp_flag_unit (WIDTH=32, CHUNK=8) with hand-computed expectations.
module tb_cmp_flag_unit;

  logic        clk;
  logic        reset;
  logic        cmp_valid;
  logic        cmp_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  cond;
  logic [31:0] diff;
  logic [3:0]  flags;
  logic        flags_valid;
  logic        done;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;

  cmp_flag_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
    .op_a(op_a), .op_b(op_b), .cond(cond), .diff(diff), .flags(flags),
    .flags_valid(flags_valid), .done(done), .branch_taken(branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request, then counts edges until done (99 if it never arrives).
  task automatic start_cmp(input logic [31:0] a, input logic [31:0] b, output int lat);
    op_a = a; op_b = b; cmp_valid = 1'b1;
    @(posedge clk); #1;
    cmp_valid = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = 99;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmp_valid = 1'b1; op_a = 32'd9; op_b = 32'd4; cond = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmp_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_low got %b want 0", cmp_ready); end
    reset = 1'b0; cmp_valid = 1'b0;
    #1;
    checks++;
    if (cmp_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_dominates got ready %b want 1", cmp_ready); end
    checks++;
    if (diff !== 32'd0 || flags !== 4'd0 || flags_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state got diff %h flags %b fv %b done %b want 0", diff, flags, flags_valid, done);
    end
    checks++;
    if (branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL reset_al got %b want 1", branch_taken); end
    cond = 3'd0; #1;
    checks++;
    if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_eq_gated got %b want 0", branch_taken); end
  endtask

  task automatic test_basic();
    int lat;
    start_cmp(32'd73, 32'd17, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL basic_latency got %0d want 4", lat); end
    checks++;
    if (diff !== 32'd56 || flags !== 4'b0010 || flags_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_result got diff %0d flags %b fv %b want 56 0010 1", diff, flags, flags_valid);
    end
    cond = 3'd3; #1;
    checks++;
    if (branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL basic_geu got %b want 1", branch_taken); end
    cond = 3'd2; #1;
    checks++;
    if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL basic_ltu got %b want 0", branch_taken); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || flags_valid !== 1'b1 || diff !== 32'd56) begin
      errors++; $display("[TB] FAIL basic_done_pulse got done %b fv %b diff %0d want 0 1 56", done, flags_valid, diff);
    end
  endtask

  task automatic test_equal();
    int lat;
    start_cmp(32'd5, 32'd5, lat);
    checks++;
    if (lat !== 4 || diff !== 32'd0 || flags !== 4'b0110) begin
      errors++; $display("[TB] FAIL equal_result got lat %0d diff %h flags %b want 4 0 0110", lat, diff, flags);
    end
    cond = 3'd0; #1;
    checks++;
    if (branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL equal_eq got %b want 1", branch_taken); end
    cond = 3'd1; #1;
    checks++;
    if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL equal_ne got %b want 0", branch_taken); end
  endtask

  task automatic test_borrow();
    int lat;
    start_cmp(32'd0, 32'd1, lat);
    checks++;
    if (lat !== 4 || diff !== 32'hFFFF_FFFF || flags !== 4'b1000) begin
      errors++; $display("[TB] FAIL borrow_result got lat %0d diff %h flags %b want 4 ffffffff 1000", lat, diff, flags);
    end
    cond = 3'd2; #1;
    checks++;
    if (branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL borrow_ltu got %b want 1", branch_taken); end
    cond = 3'd4; #1;
    checks++;
    if (branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL borrow_lt got %b want 1", branch_taken); end
    cond = 3'd5; #1;
    checks++;
    if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL borrow_ge got %b want 0", branch_taken); end
  endtask

  task automatic test_overflow();
    int lat;
    start_cmp(32'h8000_0000, 32'd1, lat);
    checks++;
    if (lat !== 4 || diff !== 32'h7FFF_FFFF || flags !== 4'b0011) begin
      errors++; $display("[TB] FAIL overflow_result got lat %0d diff %h flags %b want 4 7fffffff 0011", lat, diff, flags);
    end
    cond = 3'd4; #1;
    checks++;
    if (branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL overflow_lt got %b want 1", branch_taken); end
    cond = 3'd3; #1;
    checks++;
    if (branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL overflow_geu got %b want 1", branch_taken); end
    cond = 3'd7; #1;
    checks++;
    if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL overflow_nv got %b want 0", branch_taken); end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    op_a = 32'd73; op_b = 32'd17; cmp_valid = 1'b1;
    @(posedge clk); #1;
    cmp_valid = 1'b0; cond = 3'd3;
    checks++;
    if (flags_valid !== 1'b0 || cmp_ready !== 1'b0 || diff !== 32'h7FFF_FFFF || branch_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL calc_gating got fv %b ready %b diff %h br %b want 0 0 7fffffff 0", flags_valid, cmp_ready, diff, branch_taken);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cond = 3'd6;
    #1;
    checks++;
    if (cmp_ready !== 1'b1 || diff !== 32'd0 || flags !== 4'd0 || flags_valid !== 1'b0 || done !== 1'b0 || branch_taken !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_reset got ready %b diff %h flags %b fv %b done %b br %b", cmp_ready, diff, flags, flags_valid, done, branch_taken);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL mid_reset_no_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    op_a = 32'd10; op_b = 32'd3; cmp_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 32'd100; op_b = 32'd1;
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || diff !== 32'd7 || flags_valid !== 1'b1 || cmp_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_first got lat %0d diff %0d fv %b ready %b want 4 7 1 1", lat, diff, flags_valid, cmp_ready);
    end
    @(posedge clk); #1;
    cmp_valid = 1'b0;
    checks++;
    if (flags_valid !== 1'b0 || done !== 1'b0 || diff !== 32'd7 || cmp_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_accept got fv %b done %b diff %0d ready %b want 0 0 7 0", flags_valid, done, diff, cmp_ready);
    end
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || diff !== 32'd99 || flags !== 4'b0010 || flags_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_second got lat %0d diff %0d flags %b fv %b want 4 99 0010 1", lat, diff, flags, flags_valid);
    end
  endtask

  initial begin
    reset = 1'b1; cmp_valid = 1'b0; op_a = '0; op_b = '0; cond = 3'd0;
    test_reset();
    test_basic();
    test_equal();
    test_borrow();
    test_overflow();
    test_reset_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_flag_unit.md
CMP_FLAG_UNIT -- requirements
Module: cmp_flag_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/difference width in bits.
REQ-002 Parameter: CHUNK, default 8, bits subtracted per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: cmp_valid  input  1  compare request.
REQ-006 Port: cmp_ready  output  1  unit can accept a request this cycle.
REQ-007 Port: op_a  input  WIDTH  minuend, sampled on acceptance.
REQ-008 Port: op_b  input  WIDTH  subtrahend, sampled on acceptance.
REQ-009 Port: cond  input  3  branch condition code, evaluated combinationally.
REQ-010 Port: diff  output  WIDTH  registered result op_a - op_b (mod 2^WIDTH).
REQ-011 Port: flags  output  4  registered {N,Z,C,V}.
REQ-012 Port: flags_valid  output  1  diff/flags hold a completed, current result.
REQ-013 Port: done  output  1  one-cycle completion pulse.
REQ-014 Port: branch_taken  output  1  cond evaluated against flags.

Function
REQ-015 States SHALL be IDLE and CALC, plus a chunk counter 0..NCHUNK-1.
REQ-016 cmp_ready SHALL be 1 exactly when state is IDLE and reset is 0.
REQ-017 Acceptance: edge with cmp_valid=1 and cmp_ready=1 -> latch op_a/op_b, carry=1, counter=0, flags_valid=0, state CALC.
REQ-018 cmp_valid while in CALC SHALL be ignored; operand changes after acceptance SHALL have no effect.
REQ-019 In CALC, each edge processes chunk k (LSB first): work[k] = a[k] + ~b[k] + carry; carry = carry-out of that chunk; counter increments.
REQ-020 On the edge processing chunk NCHUNK-1: diff <= full work result, flags updated, flags_valid <= 1, done <= 1, state <= IDLE.
REQ-021 diff and flags SHALL update atomically only at completion; partial results SHALL never appear on diff.
REQ-022 Latency: done high in the cycle following the NCHUNK-th edge after the acceptance edge; back-to-back acceptance allowed in the same cycle done is high.
REQ-023 done SHALL be high for exactly one cycle per completed compare.
REQ-024 N = diff[WIDTH-1]; Z = (diff == 0); C = final carry-out (1 = no borrow, op_a >= op_b unsigned); V = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-025 cond: 0 EQ=Z, 1 NE=!Z, 2 LTU=!C, 3 GEU=C, 4 LT=N^V, 5 GE=!(N^V), 6 AL=1, 7 NV=0.
REQ-026 branch_taken SHALL equal the cond result when flags_valid=1; when flags_valid=0 it SHALL be 1 for AL and 0 for all other codes.
REQ-027 flags_valid SHALL drop to 0 on acceptance of a new compare and return to 1 at its completion (stale flags never qualify a branch).

Reset
REQ-028 reset=1 at an edge, in any state including mid-CALC: state IDLE, counter 0, diff 0, flags 0, flags_valid 0, done 0; in-flight compare discarded.
REQ-029 reset SHALL dominate cmp_valid in the same cycle; no request is accepted while reset=1.

Verification (WIDTH=32, CHUNK=8)
REQ-030 op_a=73, op_b=17 accepted -> done 4 edges later; diff=56, flags N0 Z0 C1 V0; cond=3 -> branch_taken=1, cond=2 -> 0.
REQ-031 op_a=5, op_b=5 -> diff=0, Z=1, C=1; cond=0 taken, cond=1 not taken.
REQ-032 op_a=0, op_b=1 -> diff=0xFFFFFFFF, N1 Z0 C0 V0; LTU and LT taken, cross-chunk borrow verified.
REQ-033 op_a=0x80000000, op_b=1 -> diff=0x7FFFFFFF, N0 C1 V1; LT taken, GEU taken.
REQ-034 Reset asserted on 2nd CALC edge -> next cycle cmp_ready=1, diff=0, flags=0, flags_valid=0, done never pulses; cond=6 still taken.
REQ-035 cmp_valid held high with new operands during CALC -> ignored; request presented in the done cycle accepted, flags_valid=0 until its own done.
